bcd_count_ctrl: RTL and testbench



---
 rtl/bcd_count_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// ============================================================================
//  Module      : bcd_count_ctrl
//  Description : Two-digit BCD counter with run/stop control, prescaler,
//                clear, validated load and wrap carry/borrow pulse.
//                Optional macro BCD_COUNT_DOWN_EN enables down counting (dir).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_count_ctrl #(
    parameter int DIV    = 50000000,
    parameter int MODULO = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       load_err,
    output logic       running
);

    localparam int             PW           = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  c_PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]     c_MAX_TENS   = 4'((MODULO - 1) / 10);
    localparam logic [3:0]     c_MAX_ONES   = 4'((MODULO - 1) % 10);
    localparam logic [7:0]     c_MODULO     = 8'(MODULO);

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     ones_q, ones_d;
    logic [3:0]     tens_q, tens_d;
    logic           carry_q, carry_d;
    logic           load_err_q, load_err_d;
    logic           running_q;

    logic           w_tick;
    logic [7:0]     w_load_val;
    logic           w_load_ok;
    logic [3:0]     w_up_ones, w_up_tens;
    logic           w_up_wrap;

    assign w_tick     = (state_q == ST_RUN) && (presc_q == c_PRESC_LAST);
    assign w_load_val = ({4'd0, load_tens} * 8'd10) + {4'd0, load_ones};
    assign w_load_ok  = (load_ones <= 4'd9) && (load_tens <= 4'd9) && (w_load_val < c_MODULO);

    always_comb begin
        w_up_ones = ones_q + 4'd1;
        w_up_tens = tens_q;
        w_up_wrap = 1'b0;
        if ((tens_q == c_MAX_TENS) && (ones_q == c_MAX_ONES)) begin
            w_up_ones = 4'd0;
            w_up_tens = 4'd0;
            w_up_wrap = 1'b1;
        end else if (ones_q == 4'd9) begin
            w_up_ones = 4'd0;
            w_up_tens = tens_q + 4'd1;
        end
    end

`ifdef BCD_COUNT_DOWN_EN
    logic [3:0] w_dn_ones, w_dn_tens;
    logic       w_dn_wrap;

    always_comb begin
        w_dn_ones = ones_q - 4'd1;
        w_dn_tens = tens_q;
        w_dn_wrap = 1'b0;
        if ((tens_q == 4'd0) && (ones_q == 4'd0)) begin
            w_dn_ones = c_MAX_ONES;
            w_dn_tens = c_MAX_TENS;
            w_dn_wrap = 1'b1;
        end else if (ones_q == 4'd0) begin
            w_dn_ones = 4'd9;
            w_dn_tens = tens_q - 4'd1;
        end
    end
`else
    // Up-only build: dir stays on the port list but drives nothing.
    logic w_unused_dir;
    assign w_unused_dir = dir;
`endif

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        case (state_q)
            ST_STOP: if (start && !stop) state_d = ST_RUN;
            ST_RUN:  if (stop)           state_d = ST_STOP;
            default:                     state_d = ST_STOP;
        endcase

        if (state_q == ST_RUN) begin
            presc_d = w_tick ? '0 : presc_q + PW'(1);
        end else if (state_d == ST_RUN) begin
            presc_d = '0;
        end

        // clear beats load beats tick; a rejected load still eats the tick.
        if (clear) begin
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            presc_d = '0;
        end else if (load) begin
            if (w_load_ok) begin
                ones_d  = load_ones;
                tens_d  = load_tens;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (w_tick) begin
`ifdef BCD_COUNT_DOWN_EN
            if (dir) begin
                ones_d  = w_dn_ones;
                tens_d  = w_dn_tens;
                carry_d = w_dn_wrap;
            end else
`endif
            begin
                ones_d  = w_up_ones;
                tens_d  = w_up_tens;
                carry_d = w_up_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            presc_q    <= '0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            running_q  <= (state_d == ST_RUN);
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign running  = running_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
// ============================================================================
//  Module      : tb_bcd_count_ctrl
//  Description : Directed self-checking bench for bcd_count_ctrl using three
//                parameterisations (DIV/MODULO = 4/60, 1/12, 1/60).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_count_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, stop, clear, dir, load;
    logic [3:0] load_tens, load_ones;

    logic [3:0] ones_a, tens_a, ones_b, tens_b, ones_c, tens_c;
    logic       carry_a, lerr_a, run_a;
    logic       carry_b, lerr_b, run_b;
    logic       carry_c, lerr_c, run_c;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_count_ctrl #(.DIV(4), .MODULO(60)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .ones(ones_a), .tens(tens_a), .carry(carry_a), .load_err(lerr_a),
        .running(run_a)
    );

    bcd_count_ctrl #(.DIV(1), .MODULO(12)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .ones(ones_b), .tens(tens_b), .carry(carry_b), .load_err(lerr_b),
        .running(run_b)
    );

    bcd_count_ctrl #(.DIV(1), .MODULO(60)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .ones(ones_c), .tens(tens_c), .carry(carry_c), .load_err(lerr_c),
        .running(run_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; clear = 0; dir = 0; load = 0;
        load_tens = 0; load_ones = 0;
        rst_n = 0;
        #12;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1; load_tens = t; load_ones = o;
        step();
        load = 0;
    endtask

    task automatic test_reset();
        start = 0; stop = 0; clear = 0; dir = 0; load = 0;
        load_tens = 0; load_ones = 0;
        rst_n = 1;
        #3;
        rst_n = 0;
        #3;
        n_cmp++;
        if ({tens_a, ones_a, carry_a, lerr_a, run_a} !== 11'd0) begin
            n_bad++; $display("FAIL reset_a: got %h required 000", {tens_a, ones_a, carry_a, lerr_a, run_a});
        end
        n_cmp++;
        if ({tens_b, ones_b, carry_b, lerr_b, run_b} !== 11'd0) begin
            n_bad++; $display("FAIL reset_b: got %h required 000", {tens_b, ones_b, carry_b, lerr_b, run_b});
        end
        n_cmp++;
        if ({tens_c, ones_c, carry_c, lerr_c, run_c} !== 11'd0) begin
            n_bad++; $display("FAIL reset_c: got %h required 000", {tens_c, ones_c, carry_c, lerr_c, run_c});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (3) step();
        n_cmp++;
        if ({tens_a, ones_a, carry_a, run_a} !== 10'd0) begin
            n_bad++; $display("FAIL reset_idle: got %h required 000", {tens_a, ones_a, carry_a, run_a});
        end
    endtask

    task automatic test_start();
        do_reset();
        start = 1; step(); start = 0;
        n_cmp++;
        if (run_a !== 1'b1) begin
            n_bad++; $display("FAIL start_running: got %b required 1", run_a);
        end
        repeat (3) step();
        n_cmp++;
        if ({tens_a, ones_a} !== 8'h00) begin
            n_bad++; $display("FAIL start_before4: got %h required 00", {tens_a, ones_a});
        end
        step();
        n_cmp++;
        if ({tens_a, ones_a} !== 8'h01) begin
            n_bad++; $display("FAIL start_at4: got %h required 01", {tens_a, ones_a});
        end
        repeat (3) step();
        n_cmp++;
        if ({tens_a, ones_a} !== 8'h01) begin
            n_bad++; $display("FAIL start_before8: got %h required 01", {tens_a, ones_a});
        end
        step();
        n_cmp++;
        if ({tens_a, ones_a, run_a} !== 9'h005) begin
            n_bad++; $display("FAIL start_at8: got %h required 005", {tens_a, ones_a, run_a});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ev;
        logic       ec;
        do_reset();
        do_load(4'd5, 4'd8);
        n_cmp++;
        if ({tens_a, ones_a} !== 8'h58) begin
            n_bad++; $display("FAIL wrap_load: got %h required 58", {tens_a, ones_a});
        end
        start = 1; step(); start = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            ev = (i < 4) ? 8'h58 : (i < 8) ? 8'h59 : 8'h00;
            ec = (i == 8);
            n_cmp++;
            if ({tens_a, ones_a, carry_a} !== {ev, ec}) begin
                n_bad++;
                $display("FAIL wrap_seq[%0d]: got value %h carry %b required value %h carry %b",
                         i, {tens_a, ones_a}, carry_a, ev, ec);
            end
        end
    endtask

    task automatic test_mod12();
        logic [7:0] ev [4];
        logic       ec [4];
        ev = '{8'h10, 8'h11, 8'h00, 8'h01};
        ec = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        do_load(4'd0, 4'd9);
        start = 1; step(); start = 0;
        n_cmp++;
        if ({tens_b, ones_b, carry_b} !== {8'h09, 1'b0}) begin
            n_bad++; $display("FAIL mod12_start: got %h required 09", {tens_b, ones_b});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({tens_b, ones_b, carry_b} !== {ev[i], ec[i]}) begin
                n_bad++;
                $display("FAIL mod12_seq[%0d]: got value %h carry %b required value %h carry %b",
                         i, {tens_b, ones_b}, carry_b, ev[i], ec[i]);
            end
        end
    endtask

    task automatic test_down();
        logic [7:0] ev [3];
        logic       ec [3];
`ifdef BCD_COUNT_DOWN_EN
        ev = '{8'h00, 8'h59, 8'h58};
        ec = '{1'b0, 1'b1, 1'b0};
`else
        ev = '{8'h02, 8'h03, 8'h04};
        ec = '{1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        dir = 1;
        do_load(4'd0, 4'd1);
        start = 1; step(); start = 0;
        n_cmp++;
        if ({tens_c, ones_c} !== 8'h01) begin
            n_bad++; $display("FAIL down_start: got %h required 01", {tens_c, ones_c});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({tens_c, ones_c, carry_c} !== {ev[i], ec[i]}) begin
                n_bad++;
                $display("FAIL down_seq[%0d]: got value %h carry %b required value %h carry %b",
                         i, {tens_c, ones_c}, carry_c, ev[i], ec[i]);
            end
        end
        dir = 0;
    endtask

    task automatic test_load_reject();
        do_reset();
        do_load(4'd2, 4'd3);
        n_cmp++;
        if ({tens_a, ones_a, lerr_a} !== {8'h23, 1'b0}) begin
            n_bad++; $display("FAIL load_ok: got %h err %b required 23 err 0", {tens_a, ones_a}, lerr_a);
        end
        do_load(4'd6, 4'd0);
        n_cmp++;
        if ({tens_a, ones_a, lerr_a} !== {8'h23, 1'b1}) begin
            n_bad++; $display("FAIL load_rej60: got %h err %b required 23 err 1", {tens_a, ones_a}, lerr_a);
        end
        step();
        n_cmp++;
        if (lerr_a !== 1'b0) begin
            n_bad++; $display("FAIL load_err_width: got %b required 0", lerr_a);
        end
        do_load(4'd0, 4'hA);
        n_cmp++;
        if ({tens_a, ones_a, lerr_a} !== {8'h23, 1'b1}) begin
            n_bad++; $display("FAIL load_rejA: got %h err %b required 23 err 1", {tens_a, ones_a}, lerr_a);
        end
        clear = 1;
        do_load(4'd6, 4'd0);
        clear = 0;
        n_cmp++;
        if ({tens_a, ones_a, lerr_a, carry_a} !== {8'h00, 2'b00}) begin
            n_bad++; $display("FAIL load_clear: got %h err %b required 00 err 0", {tens_a, ones_a}, lerr_a);
        end
    endtask

    task automatic test_reject_tick();
        do_reset();
        do_load(4'd0, 4'd5);
        start = 1; step(); start = 0;
        step();
        n_cmp++;
        if ({tens_b, ones_b} !== 8'h06) begin
            n_bad++; $display("FAIL rejtick_run: got %h required 06", {tens_b, ones_b});
        end
        do_load(4'd1, 4'd5);
        n_cmp++;
        if ({tens_b, ones_b, lerr_b} !== {8'h06, 1'b1}) begin
            n_bad++; $display("FAIL rejtick_hold: got %h err %b required 06 err 1", {tens_b, ones_b}, lerr_b);
        end
        step();
        n_cmp++;
        if ({tens_b, ones_b, lerr_b} !== {8'h07, 1'b0}) begin
            n_bad++; $display("FAIL rejtick_resume: got %h err %b required 07 err 0", {tens_b, ones_b}, lerr_b);
        end
        clear = 1; step(); clear = 0;
        n_cmp++;
        if ({tens_b, ones_b, carry_b, run_b} !== {8'h00, 2'b01}) begin
            n_bad++; $display("FAIL clear_run: got %h carry %b run %b required 00 0 1", {tens_b, ones_b}, carry_b, run_b);
        end
    endtask

    task automatic test_control();
        do_reset();
        start = 1; stop = 1; step(); start = 0; stop = 0;
        n_cmp++;
        if (run_a !== 1'b0) begin
            n_bad++; $display("FAIL start_stop_same: got %b required 0", run_a);
        end
        start = 1; step(); start = 0;
        repeat (5) step();
        n_cmp++;
        if ({tens_a, ones_a, run_a} !== 9'h003) begin
            n_bad++; $display("FAIL ctrl_count: got %h required 003", {tens_a, ones_a, run_a});
        end
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if ({tens_a, ones_a, carry_a, lerr_a, run_a} !== 11'd0) begin
            n_bad++; $display("FAIL async_reset: got %h required 000", {tens_a, ones_a, carry_a, lerr_a, run_a});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (6) step();
        n_cmp++;
        if ({tens_a, ones_a, carry_a, run_a} !== 10'd0) begin
            n_bad++; $display("FAIL post_reset: got %h required 000", {tens_a, ones_a, carry_a, run_a});
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap();
        test_mod12();
        test_down();
        test_load_reject();
        test_reject_tick();
        test_control();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
